inst_mem_pipe: RTL and testbench
================================

Name: inst_mem_pipe

Overview:
- Byte-addressed instruction memory for the pipelined RISC-V core, sitting in the fetch stage.
- Successor to the combinational fetch memory: parametrised in depth and byte order, with a registered read port (1-cycle latency).
- Adds a valid/ready request handshake, a stall/flush interface to the pipeline, and fault detection for misaligned or out-of-range PCs.
- An optional program-loader write port allows test programs to be written at run time instead of only at elaboration.

Parameters:
- ADDR_WIDTH, 32, width of pc and load_addr.
- DEPTH_BYTES, 1024, memory size in bytes; must be a power of two and at least 4.
- BIG_ENDIAN, 1. When 1, byte[a] is inst[31:24] and byte[a+3] is inst[7:0]. When 0, byte order is little-endian.
- NOP_WORD, 32'h00000013, word returned on fault or flush (addi x0,x0,0).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted this cycle.
- pc  in  ADDR_WIDTH  byte address of the instruction to fetch.
- stall  in  1  pipeline stall; hold the current response.
- flush  in  1  kill the in-flight response (branch/jump taken).
- resp_valid  out  1  resp_inst is valid.
- resp_inst  out  32  fetched instruction word.
- resp_pc  out  ADDR_WIDTH  pc of the returned instruction.
- resp_fault  out  1  fetch was misaligned (pc[1:0]!=0) or pc >= DEPTH_BYTES.
- load_en  in  1  loader write strobe (IMEM_LOADER_EN only).
- load_addr  in  ADDR_WIDTH  loader byte address, word-aligned (IMEM_LOADER_EN only).
- load_data  in  32  loader word, byte order per BIG_ENDIAN (IMEM_LOADER_EN only).

Behaviour:
- Reset (asynchronous assert, synchronous release): resp_valid=0, resp_inst=NOP_WORD, resp_pc=0, resp_fault=0. Memory contents are not reset; they are zero-initialised at elaboration.
- req_ready = !stall && !load_busy. load_busy is load_en when IMEM_LOADER_EN is defined, else 0.
- Accept occurs when req_valid && req_ready. On the next rising edge:
  - resp_valid=1 and resp_pc=pc.
  - resp_inst holds the 4 bytes at pc..pc+3, assembled per BIG_ENDIAN.
- Fault: if pc[1:0]!=0 or pc >= DEPTH_BYTES, then resp_fault=1 and resp_inst=NOP_WORD. No array access wraps around.
- No accept and no stall: on the next edge resp_valid=0; resp_inst and resp_pc hold their previous values.
- stall=1: all resp_* outputs hold unchanged (including resp_valid=1), and no new request is accepted.
- flush=1 has priority over stall and accept. On the next edge:
  - resp_valid=0, resp_inst=NOP_WORD, resp_fault=0.
  - Any request presented in the same cycle is dropped; req_ready stays as computed, but the capture is discarded.
- flush and stall together: flush wins.
- Read-during-write at the same word: the response returns the OLD contents; the new word is visible from the following cycle.
- Control FSM states:
  - IDLE (resp_valid=0)
  - VALID (resp_valid=1)
  - HOLD (VALID while stall=1)
- FSM transitions:
  - IDLE -> VALID on accept.
  - VALID -> HOLD on stall.
  - HOLD -> VALID when stall drops.
  - any state -> IDLE on flush, or when there is no accept and no stall.
- Reset in mid-operation forces IDLE immediately, without waiting for a clock edge.
- Address width: DEPTH_BYTES is indexed by pc[$clog2(DEPTH_BYTES)-1:0] only after the range check passes.

Optional Feature:
- IMEM_LOADER_EN defined:
  - A rising edge with load_en=1 and load_addr word-aligned and in range writes load_data to the 4 bytes at load_addr.
  - Misaligned or out-of-range loader writes are ignored.
  - req_ready=0 while load_en=1.
- IMEM_LOADER_EN undefined:
  - Loader ports exist but are ignored; no write logic is synthesised.
  - Memory is read-only, with contents fixed at elaboration.

Test Plan:
- Word at byte 0 = 00 40 01 13, BIG_ENDIAN=1; req pc=0 for one cycle -> next cycle resp_valid=1, resp_inst=32'h00400113, resp_pc=0, resp_fault=0.
- Same bytes with BIG_ENDIAN=0, pc=0 -> resp_inst=32'h13014000.
- pc=2 -> resp_fault=1, resp_inst=32'h00000013. Separately, pc=DEPTH_BYTES (1024) -> resp_fault=1 with no wrap to address 0.
- Accept pc=16, then stall=1 for 3 cycles with pc=20 presented -> resp_pc stays 16 and req_ready=0 for 3 cycles; pc=20 returns the cycle after stall drops.
- flush and stall asserted together with response valid -> next cycle resp_valid=0, resp_inst=NOP_WORD. Reset asserted mid-response -> resp_valid=0 immediately, without a clock edge.
- (IMEM_LOADER_EN) write 32'hDEADBEEF at 32 while reading pc=32 -> old value returned; read again next cycle -> 32'hDEADBEEF. A write at address 34 is ignored.

Source files
------------

// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: fetch-stage instruction memory with a registered read port, valid/ready handshake,
// stall/flush control and PC fault detection. Define IMEM_LOADER_EN to build the run-time loader write port.
module inst_mem_pipe #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter bit          BIG_ENDIAN  = 1'b1,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  resp_valid,
   output logic [31:0]           resp_inst,
   output logic [ADDR_WIDTH-1:0] resp_pc,
   output logic                  resp_fault,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [31:0]           load_data
);
   localparam int unsigned         IDX_W     = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_BYTES);

   typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_HOLD} state_t;

   state_t                  state_q, state_d;
   logic [31:0]             inst_q, inst_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    fault_q, fault_d;
   logic [7:0]              mem_q [DEPTH_BYTES] = '{default: 8'h00};

   logic                    load_busy;
   logic                    accept;
   logic                    pc_fault;
   logic [IDX_W-1:0]        rd_idx;
   logic [31:0]             rd_word;

   // b0 is the byte at the lowest address of the word
   function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
      return BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
   endfunction

   assign req_ready = !stall && !load_busy;
   assign accept    = req_valid && req_ready;
   // The widened compare keeps pc values beyond the array from aliasing onto low addresses
   assign pc_fault  = (pc[1:0] != 2'b00) || ({1'b0, pc} >= DEPTH_EXT);
   assign rd_idx    = pc[IDX_W-1:0];
   assign rd_word   = pack_word(mem_q[rd_idx], mem_q[rd_idx | IDX_W'(1)],
                                mem_q[rd_idx | IDX_W'(2)], mem_q[rd_idx | IDX_W'(3)]);

   always_comb begin
      state_d = ST_IDLE;
      if (flush) begin
         state_d = ST_IDLE;
      end else if (stall) begin
         state_d = (state_q == ST_IDLE) ? ST_IDLE : ST_HOLD;
      end else if (accept) begin
         state_d = ST_VALID;
      end
   end

   always_comb begin
      inst_d  = inst_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      if (flush) begin
         inst_d  = NOP_WORD;
         fault_d = 1'b0;
      end else if (accept) begin
         inst_d  = pc_fault ? NOP_WORD : rd_word;
         pc_d    = pc;
         fault_d = pc_fault;
      end
   end

   // Response stage boundary
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         inst_q  <= NOP_WORD;
         pc_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   assign resp_valid = (state_q != ST_IDLE);
   assign resp_inst  = inst_q;
   assign resp_pc    = pc_q;
   assign resp_fault = fault_q;

`ifdef IMEM_LOADER_EN
   logic             load_ok;
   logic [IDX_W-1:0] wr_idx;

   function automatic logic [7:0] lane_byte(input logic [31:0] w, input int k);
      return BIG_ENDIAN ? w[8*(3-k) +: 8] : w[8*k +: 8];
   endfunction

   assign load_busy = load_en;
   assign load_ok   = load_en && (load_addr[1:0] == 2'b00) && ({1'b0, load_addr} < DEPTH_EXT);
   assign wr_idx    = load_addr[IDX_W-1:0];

   // Same-edge reads see the old bytes; the new word is visible from the next cycle
   always_ff @(posedge clock) begin
      if (load_ok) begin
         for (int k = 0; k < 4; k++) begin
            mem_q[wr_idx | IDX_W'(k)] <= lane_byte(load_data, k);
         end
      end
   end
`else
   logic unused_loader;
   assign load_busy     = 1'b0;
   assign unused_loader = ^{load_en, load_addr, load_data};
`endif

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: big- and little-endian instances share stimulus and are checked
// against a byte-array reference model of the fetch memory.
module tb_inst_mem_pipe;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset, req_valid, stall, flush, load_en;
   logic [31:0] pc, load_addr, ld_be, ld_le;
   logic        rdy_be, rdy_le, v_be, v_le, f_be, f_le;
   logic [31:0] inst_be, inst_le, rpc_be, rpc_le;

   int          n_vec = 0;
   int          n_err = 0;

   logic [7:0]  ref_mem [DEPTH];
   logic        exp_v, exp_f;
   logic [31:0] exp_be, exp_le, exp_pc;

   inst_mem_pipe #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b1), .NOP_WORD(NOP)) dut_be (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy_be), .pc(pc),
      .stall(stall), .flush(flush), .resp_valid(v_be), .resp_inst(inst_be), .resp_pc(rpc_be),
      .resp_fault(f_be), .load_en(load_en), .load_addr(load_addr), .load_data(ld_be));

   inst_mem_pipe #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .BIG_ENDIAN(1'b0), .NOP_WORD(NOP)) dut_le (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy_le), .pc(pc),
      .stall(stall), .flush(flush), .resp_valid(v_le), .resp_inst(inst_le), .resp_pc(rpc_le),
      .resp_fault(f_le), .load_en(load_en), .load_addr(load_addr), .load_data(ld_le));

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   function automatic logic [31:0] ref_word(input int a, input bit big);
      if (big) return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
      return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
   endfunction

   task automatic model_reset();
      exp_v = 1'b0; exp_f = 1'b0; exp_pc = '0; exp_be = NOP; exp_le = NOP;
   endtask

   task automatic drive(input logic rv, input logic [31:0] p, input logic st, input logic fl);
      req_valid = rv; pc = p; stall = st; flush = fl;
   endtask

   // The little-endian instance gets a byte-swapped word so both memories hold the same bytes
   task automatic drive_load(input logic en, input logic [31:0] a, input logic [31:0] w);
      load_en = en; load_addr = a; ld_be = w;
      ld_le = {w[7:0], w[15:8], w[23:16], w[31:24]};
   endtask

   // One clock: the model follows the fetch rules using the inputs present at the edge
   task automatic tick();
      logic busy, acc, bad;
      @(posedge clock);
`ifdef IMEM_LOADER_EN
      busy = load_en;
`else
      busy = 1'b0;
`endif
      acc = req_valid && !stall && !busy;
      bad = (pc % 4 != 0) || (pc >= DEPTH);
      if (reset) begin
         model_reset();
      end else if (flush) begin
         exp_v = 1'b0; exp_be = NOP; exp_le = NOP; exp_f = 1'b0;
      end else if (!stall) begin
         if (acc) begin
            exp_v = 1'b1; exp_pc = pc; exp_f = bad;
            exp_be = bad ? NOP : ref_word(int'(pc), 1'b1);
            exp_le = bad ? NOP : ref_word(int'(pc), 1'b0);
         end else begin
            exp_v = 1'b0;
         end
      end
`ifdef IMEM_LOADER_EN
      if (!reset && load_en && (load_addr % 4 == 0) && (load_addr < DEPTH))
         for (int k = 0; k < 4; k++) ref_mem[int'(load_addr) + k] = ld_be[31-8*k -: 8];
`endif
      @(negedge clock);
   endtask

   task automatic poke(input int a, input logic [31:0] w);
`ifdef IMEM_LOADER_EN
      drive(1'b0, '0, 1'b0, 1'b0);
      drive_load(1'b1, a, w);
      tick();
      drive_load(1'b0, '0, '0);
`else
      for (int k = 0; k < 4; k++) begin
         dut_be.mem_q[a+k] = w[31-8*k -: 8];
         dut_le.mem_q[a+k] = w[31-8*k -: 8];
         ref_mem[a+k]      = w[31-8*k -: 8];
      end
`endif
   endtask

   task automatic test_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      drive_load(1'b0, '0, '0);
      model_reset();
      repeat (2) @(negedge clock);
      #1;
      n_vec++;
      if ({v_be, f_be, rpc_be, inst_be, v_le, f_le, rpc_le, inst_le} !== {2'b00, 32'h0, NOP, 2'b00, 32'h0, NOP}) begin
         n_err++;
         $display("FAIL reset_state: got v=%b f=%b pc=%h inst=%h / v=%b f=%b pc=%h inst=%h, expected v=0 f=0 pc=0 inst=%h",
                  v_be, f_be, rpc_be, inst_be, v_le, f_le, rpc_le, inst_le, NOP);
      end
      n_vec++;
      if (rdy_be !== 1'b1 || rdy_le !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got %b/%b, expected 1", rdy_be, rdy_le);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_endian();
      poke(0, 32'h0040_0113);
      drive(1'b1, 32'd0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_vec++;
      if ({v_be, f_be, rpc_be, inst_be, inst_le} !== {2'b10, 32'h0, 32'h0040_0113, 32'h1301_4000}) begin
         n_err++;
         $display("FAIL endian_pc0: got v=%b f=%b pc=%h be=%h le=%h, expected v=1 f=0 pc=0 be=00400113 le=13014000",
                  v_be, f_be, rpc_be, inst_be, inst_le);
      end
      tick();
      n_vec++;
      if ({v_be, v_le, inst_be, rpc_be} !== {2'b00, exp_be, exp_pc}) begin
         n_err++;
         $display("FAIL idle_hold: got v=%b/%b inst=%h pc=%h, expected v=0 inst=%h pc=%h",
                  v_be, v_le, inst_be, rpc_be, exp_be, exp_pc);
      end
   endtask

   task automatic test_fault();
      logic [31:0] pcs [7] = '{32'd2, 32'd1024, 32'd1020, 32'd1, 32'd3, 32'hFFFF_FFFC, 32'd4};
      poke(1020, 32'hCAFE_F00D);
      poke(4, 32'h1234_5678);
      foreach (pcs[i]) begin
         drive(1'b1, pcs[i], 1'b0, 1'b0);
         tick();
         n_vec++;
         if ({v_be, f_be, rpc_be, inst_be, v_le, f_le, inst_le} !== {exp_v, exp_f, exp_pc, exp_be, exp_v, exp_f, exp_le}) begin
            n_err++;
            $display("FAIL fault_pc_%h: got v=%b f=%b pc=%h be=%h le=%h, expected v=%b f=%b pc=%h be=%h le=%h",
                     pcs[i], v_be, f_be, rpc_be, inst_be, inst_le, exp_v, exp_f, exp_pc, exp_be, exp_le);
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_stall();
      poke(16, 32'hA1B2_C3D4);
      poke(20, 32'h0102_0304);
      drive(1'b1, 32'd16, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'd20, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (rdy_be !== 1'b0 || rdy_le !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready_%0d: got %b/%b, expected 0", c, rdy_be, rdy_le);
         end
         tick();
         n_vec++;
         if ({v_be, rpc_be, inst_be, inst_le} !== {1'b1, 32'd16, exp_be, exp_le} || exp_be !== 32'hA1B2_C3D4) begin
            n_err++;
            $display("FAIL stall_hold_%0d: got v=%b pc=%h be=%h le=%h, expected v=1 pc=10 be=%h le=%h",
                     c, v_be, rpc_be, inst_be, inst_le, exp_be, exp_le);
         end
      end
      drive(1'b1, 32'd20, 1'b0, 1'b0);
      #1;
      n_vec++;
      if (rdy_be !== 1'b1) begin
         n_err++;
         $display("FAIL stall_release_ready: got %b, expected 1", rdy_be);
      end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_vec++;
      if ({v_be, rpc_be, inst_be, inst_le} !== {1'b1, 32'd20, 32'h0102_0304, 32'h0403_0201}) begin
         n_err++;
         $display("FAIL stall_next: got v=%b pc=%h be=%h le=%h, expected v=1 pc=14 be=01020304 le=04030201",
                  v_be, rpc_be, inst_be, inst_le);
      end
   endtask

   task automatic test_flush();
      // each row: request pc, then the flush-cycle inputs {req_valid, stall}
      logic [31:0] first [4] = '{32'd16, 32'd2, 32'd20, 32'd1024};
      logic [1:0]  ctl   [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
      foreach (first[i]) begin
         drive(1'b1, first[i], 1'b0, 1'b0);
         tick();
         drive(ctl[i][1], 32'd4, ctl[i][0], 1'b1);
         tick();
         n_vec++;
         if ({v_be, f_be, inst_be, v_le, f_le, inst_le, rpc_be} !== {2'b00, NOP, 2'b00, NOP, exp_pc}) begin
            n_err++;
            $display("FAIL flush_%0d: got v=%b f=%b be=%h le=%h pc=%h, expected v=0 f=0 inst=%h pc=%h",
                     i, v_be, f_be, inst_be, inst_le, rpc_be, NOP, exp_pc);
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 32'd20, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_vec++;
      if ({v_be, f_be, rpc_be, inst_be, v_le, inst_le} !== {2'b00, 32'h0, NOP, 1'b0, NOP}) begin
         n_err++;
         $display("FAIL async_reset: got v=%b f=%b pc=%h be=%h v_le=%b le=%h, expected v=0 f=0 pc=0 inst=%h",
                  v_be, f_be, rpc_be, inst_be, v_le, inst_le, NOP);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

`ifdef IMEM_LOADER_EN
   task automatic test_loader();
      poke(32, 32'h1122_3344);
      drive(1'b1, 32'd32, 1'b0, 1'b0);
      tick();
      drive_load(1'b1, 32'd32, 32'hDEAD_BEEF);
      #1;
      n_vec++;
      if (rdy_be !== 1'b0 || rdy_le !== 1'b0) begin
         n_err++;
         $display("FAIL load_ready: got %b/%b, expected 0", rdy_be, rdy_le);
      end
      n_vec++;
      if (inst_be !== 32'h1122_3344) begin
         n_err++;
         $display("FAIL load_old: got %h, expected 11223344", inst_be);
      end
      tick();
      drive_load(1'b0, '0, '0);
      tick();
      n_vec++;
      if ({v_be, inst_be, inst_le} !== {1'b1, 32'hDEAD_BEEF, 32'hEFBE_ADDE}) begin
         n_err++;
         $display("FAIL load_new: got v=%b be=%h le=%h, expected v=1 be=deadbeef le=efbeadde", v_be, inst_be, inst_le);
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      drive_load(1'b1, 32'd34, 32'h0BAD_0BAD);
      tick();
      drive_load(1'b0, '0, '0);
      drive(1'b1, 32'd32, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_vec++;
      if ({inst_be, inst_le} !== {32'hDEAD_BEEF, 32'hEFBE_ADDE}) begin
         n_err++;
         $display("FAIL load_misaligned_ignored: got be=%h le=%h, expected be=deadbeef le=efbeadde", inst_be, inst_le);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] p;
      logic        exp_rdy;
      int          r;
      for (int i = 0; i < 24; i++) poke(4 * $urandom_range(0, DEPTH/4 - 1), $urandom);
      for (int c = 0; c < 300; c++) begin
         r = $urandom_range(0, 15);
         if (r == 0)      p = ($urandom % DEPTH) | 32'd1;
         else if (r == 1) p = DEPTH + 4 * $urandom_range(0, 64);
         else             p = 4 * $urandom_range(0, DEPTH/4 - 1);
         drive(($urandom % 4) != 0, p, ($urandom % 5) == 0, ($urandom % 10) == 0);
`ifdef IMEM_LOADER_EN
         drive_load(($urandom % 8) == 0, 4 * $urandom_range(0, DEPTH/4 + 8) + (($urandom % 6 == 0) ? 2 : 0), $urandom);
         exp_rdy = !stall && !load_en;
`else
         exp_rdy = !stall;
`endif
         #1;
         n_vec++;
         if (rdy_be !== exp_rdy || rdy_le !== exp_rdy) begin
            n_err++;
            $display("FAIL rand_ready_%0d: got %b/%b, expected %b", c, rdy_be, rdy_le, exp_rdy);
         end
         tick();
         n_vec++;
         if ({v_be, f_be, rpc_be, inst_be, v_le, f_le, rpc_le, inst_le} !==
             {exp_v, exp_f, exp_pc, exp_be, exp_v, exp_f, exp_pc, exp_le}) begin
            n_err++;
            $display("FAIL rand_resp_%0d: got v=%b f=%b pc=%h be=%h le=%h, expected v=%b f=%b pc=%h be=%h le=%h",
                     c, v_be, f_be, rpc_be, inst_be, inst_le, exp_v, exp_f, exp_pc, exp_be, exp_le);
         end
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      drive_load(1'b0, '0, '0);
   endtask

   initial begin
      test_reset();
      test_endian();
      test_fault();
      test_stall();
      test_flush();
      test_mid_reset();
`ifdef IMEM_LOADER_EN
      test_loader();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
